// File: rtl/contador_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and direction codes.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/controlador_contador_if.sv
// Command/status bundle between control logic (master) and the sequencer (slave).
interface controlador_contador_if #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
);
  logic              start;
  logic              stop;
  logic              pause;
  logic [WIDTH-1:0]  limit;
  logic [PASS_W-1:0] passes;
  logic              dir;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              wrap;
  logic              done;
  logic [PASS_W-1:0] pass_cnt;

  modport master (
    output start, stop, pause, limit, passes, dir,
    input  q, busy, wrap, done, pass_cnt
  );

  modport slave (
    input  start, stop, pause, limit, passes, dir,
    output q, busy, wrap, done, pass_cnt
  );
endinterface

// File: rtl/contador_carga.sv
// Loadable WIDTH-bit counter; clr > load > en. Down path only with CONTADOR_DOWN_EN.
module contador_carga
  import contador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

`ifndef CONTADOR_DOWN_EN
  logic unused_dir;
  assign unused_dir = dir;
`endif

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
`ifdef CONTADOR_DOWN_EN
      q_d = (dir == DIR_DOWN) ? q_q - WIDTH'(1) : q_q + WIDTH'(1);
`else
      q_d = q_q + WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/controlador_contador.sv
// Multi-pass sequencer driving a loadable counter, with pause/abort.
// Build macro CONTADOR_DOWN_EN enables the dir input and the down-count path.
module controlador_contador
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  controlador_contador_if.slave  bus
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dir_q;

  logic              cnt_load, cnt_en;
  logic [WIDTH-1:0]  cnt_load_val;
  logic [WIDTH-1:0]  q;
  logic              terminal, last_pass;
  logic [PASS_W-1:0] pass_inc;
  logic [WIDTH-1:0]  start_val;

`ifdef CONTADOR_DOWN_EN
  logic dir_d;
  assign terminal  = (dir_q == DIR_DOWN) ? (q == '0) : (q == limit_q);
  assign start_val = (dir_q == DIR_DOWN) ? limit_q : '0;
`else
  logic unused_dir;
  assign unused_dir = bus.dir;
  assign dir_q      = DIR_UP;
  assign terminal   = (q == limit_q);
  assign start_val  = '0;
`endif

  assign pass_inc  = pass_cnt_q + PASS_W'(1);
  assign last_pass = (pass_inc == passes_q);

  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    passes_d     = passes_q;
    pass_cnt_d   = pass_cnt_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
`ifdef CONTADOR_DOWN_EN
    dir_d        = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.stop && bus.start) begin
          limit_d    = bus.limit;
          passes_d   = (bus.passes == '0) ? PASS_W'(1) : bus.passes;
          pass_cnt_d = '0;
          cnt_load   = 1'b1;
          state_d    = RUN;
`ifdef CONTADOR_DOWN_EN
          dir_d        = bus.dir;
          cnt_load_val = (bus.dir == DIR_DOWN) ? bus.limit : '0;
`endif
        end
      end
      RUN, PAUSE: begin
        // Leaving PAUSE takes a normal count step on that same edge, so each
        // pause cycle costs exactly one cycle of run time.
        if (bus.stop) begin
          state_d    = IDLE;
          cnt_load   = 1'b1;
          pass_cnt_d = '0;
        end else if (bus.pause) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
          if (terminal) begin
            pass_cnt_d = pass_inc;
            if (last_pass) begin
              state_d = DONE;
            end else begin
              cnt_load     = 1'b1;
              cnt_load_val = start_val;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        cnt_load = 1'b1;
        if (bus.stop) pass_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CONTADOR_DOWN_EN
      dir_q      <= DIR_UP;
`endif
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CONTADOR_DOWN_EN
      dir_q      <= dir_d;
`endif
    end
  end

  contador_carga #(.WIDTH(WIDTH)) u_carga (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .dir      (dir_q),
    .q        (q)
  );

  assign bus.q        = q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.wrap     = (state_q == RUN) && terminal && !bus.pause;

endmodule

// File: tb/tb_controlador_contador.sv
// Scoreboard bench: each command's full expected output trace is queued up front,
// a negedge monitor pops and compares the entry stamped for the current cycle.
module tb_controlador_contador;

  localparam int WIDTH  = 4;
  localparam int PASS_W = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  controlador_contador_if #(.WIDTH(WIDTH), .PASS_W(PASS_W)) bus ();

  controlador_contador #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned cyc;
    int          q;
    bit          wrap;
    bit          busy;
    bit          done;
    int          pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  function automatic void push(int unsigned c, int qv, bit w, bit b, bit d, int pc);
    exp_t x;
    x.cyc = c; x.q = qv; x.wrap = w; x.busy = b; x.done = d; x.pc = pc;
    sb.push_back(x);
  endfunction

  function automatic void cmp(string name, int unsigned c, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, req);
    end
  endfunction

  // Monitor: compare whatever the DUT presents against the entry for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_entry cyc=%0d actual=none required=cyc%0d", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      cmp("q",        cyc, 32'(bus.q),        32'(e.q));
      cmp("wrap",     cyc, 32'(bus.wrap),     32'(e.wrap));
      cmp("busy",     cyc, 32'(bus.busy),     32'(e.busy));
      cmp("done",     cyc, 32'(bus.done),     32'(e.done));
      cmp("pass_cnt", cyc, 32'(bus.pass_cnt), 32'(e.pc));
    end
  end

  // mode: 0 plain, 1 pause at position pos for len cycles, 2 stop at pos, 3 clr at pos.
  // A position is one counter value of the flattened pass sequence.
  task automatic run_cmd(int lim, int np_raw, bit d, int mode, int pos, int len);
    int np, per, n, t, last_t, stray, reps, i, val;
    int unsigned s;
    bit de;
`ifdef CONTADOR_DOWN_EN
    de = d;
`else
    de = 1'b0;
`endif
    np  = (np_raw == 0) ? 1 : np_raw;
    per = lim + 1;
    n   = np * per;
    s   = cyc;
    t   = 1;
    for (int p = 0; p < ((mode >= 2) ? pos + 1 : n); p++) begin
      i    = p % per;
      val  = de ? lim - i : i;
      reps = (mode == 1 && p == pos) ? 1 + len : 1;
      for (int r = 0; r < reps; r++) begin
        push(s + t, val, (i == lim), 1'b1, 1'b0, p / per);
        t++;
      end
    end
    if (mode >= 2) begin
      push(s + t, 0, 1'b0, 1'b0, 1'b0, 0);
    end else begin
      push(s + t, de ? 0 : lim, 1'b0, 1'b1, 1'b1, np);
      t++;
      push(s + t, 0, 1'b0, 1'b0, 1'b0, np);
    end
    last_t = t;
    stray  = 1 + $urandom_range(0, (mode >= 2) ? pos : n - 1);

    bus.limit  = WIDTH'(lim);
    bus.passes = PASS_W'(np_raw);
    bus.dir    = d;
    bus.start  = 1'b1;
    @(posedge clk) #1;
    for (int tt = 1; tt <= last_t; tt++) begin
      bus.limit  = WIDTH'($urandom);
      bus.passes = PASS_W'($urandom);
      bus.dir    = 1'($urandom);
      bus.start  = (tt == stray);
      bus.pause  = (mode == 1 && tt >= pos + 1 && tt < pos + 1 + len);
      bus.stop   = (mode == 2 && tt == pos + 1);
      clr        = (mode == 3 && tt == pos + 1);
      @(posedge clk) #1;
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    clr       = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lim, np_raw, mode, pos, len, n;
    bit d;
    clr        = 1'b1;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.pause  = 1'b0;
    bus.limit  = '0;
    bus.passes = '0;
    bus.dir    = 1'b0;
    @(posedge clk) #1;
    push(cyc, 0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk) #1;
    push(cyc, 0, 1'b0, 1'b0, 1'b0, 0);
    clr = 1'b0;
    @(posedge clk) #1;

    run_cmd(3, 2, 1'b0, 0, 0, 0);
    @(posedge clk) #1;
    run_cmd(5, 1, 1'b1, 0, 0, 0);
    @(posedge clk) #1;
    run_cmd(7, 1, 1'b0, 1, 4, 3);
    @(posedge clk) #1;
    run_cmd(9, 1, 1'b0, 2, 6, 0);
    @(posedge clk) #1;
    run_cmd(9, 1, 1'b0, 3, 6, 0);
    @(posedge clk) #1;
    run_cmd(0, 3, 1'b0, 0, 0, 0);
    @(posedge clk) #1;
    run_cmd(2, 0, 1'b1, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      lim    = $urandom_range(0, 9);
      np_raw = $urandom_range(0, 3);
      d      = 1'($urandom);
      mode   = (lim == 0) ? 0 : $urandom_range(0, 3);
      n      = ((np_raw == 0) ? 1 : np_raw) * (lim + 1);
      pos    = $urandom_range(0, n - 1);
      if (pos % (lim + 1) == lim && lim > 0) pos = pos - 1;
      len    = $urandom_range(1, 4);
      run_cmd(lim, np_raw, d, mode, pos, len);
    end

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_entries actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
